// File: rtl/vend_dispenser_if.sv
// Dispense request/response bundle between the vending credit FSM and the
// dispense controller.
interface vend_dispenser_if;
  logic       A;
  logic [1:0] P;
  logic       refill;
  logic [2:0] motor;
  logic       busy;
  logic       done;
  logic       refund;
  logic [2:0] empty;
  logic [1:0] last_P;

  modport master (
    output A, P, refill,
    input  motor, busy, done, refund, empty, last_P
  );

  modport slave (
    input  A, P, refill,
    output motor, busy, done, refund, empty, last_P
  );
endinterface

// File: rtl/vend_dispenser.sv
// Product-dispense actuator controller: stock check, timed one-hot motor drive,
// settle interval, done/refund pulses and per-product inventory tracking.
module vend_dispenser #(
  parameter int unsigned MOTOR_CYCLES  = 8,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned STOCK_W       = 3,
  parameter int unsigned STOCK_INIT    = 7
) (
  input  logic            clk,
  input  logic            reset,
  vend_dispenser_if.slave bus
);

  localparam int unsigned T_MAX   = (MOTOR_CYCLES > SETTLE_CYCLES) ? MOTOR_CYCLES : SETTLE_CYCLES;
  localparam int unsigned TIMER_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;
  localparam int unsigned N_PROD  = 3;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] SETTLE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [1:0]         code_q, code_d;
  logic [STOCK_W-1:0] stock_q [N_PROD];
  logic [STOCK_W-1:0] stock_d [N_PROD];
  logic [2:0]         motor_q, motor_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               refund_q, refund_d;
  logic [2:0]         empty_q, empty_d;
  logic [1:0]         last_p_q, last_p_d;
  logic [STOCK_W-1:0] sel_stock;
  logic               accept;

  // Next-state, stock bookkeeping and registered-output precompute
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    code_d    = code_q;
    last_p_d  = last_p_q;
    done_d    = 1'b0;
    refund_d  = 1'b0;
    accept    = 1'b0;
    motor_d   = 3'b000;
    sel_stock = '0;
    for (int i = 0; i < int'(N_PROD); i++) stock_d[i] = stock_q[i];

    case (bus.P)
      2'd1:    sel_stock = stock_q[0];
      2'd2:    sel_stock = stock_q[1];
      2'd3:    sel_stock = stock_q[2];
      default: sel_stock = '0;
    endcase

    case (state_q)
      IDLE: begin
        if (bus.A) begin
          if (bus.P != 2'd0 && sel_stock != '0) begin
            accept  = 1'b1;
            code_d  = bus.P;
            timer_d = TIMER_W'(MOTOR_CYCLES - 1);
            state_d = RUN;
          end else begin
            refund_d = 1'b1;
          end
        end else if (bus.refill) begin
          for (int i = 0; i < int'(N_PROD); i++) stock_d[i] = STOCK_W'(STOCK_INIT);
        end
      end
      RUN: begin
        refund_d = bus.A;
        if (timer_q == '0) begin
          timer_d = TIMER_W'(SETTLE_CYCLES - 1);
          state_d = SETTLE;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      SETTLE: begin
        refund_d = bus.A;
        if (timer_q == '0) begin
          state_d  = IDLE;
          done_d   = 1'b1;
          last_p_d = code_q;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Accept already guarantees nonzero stock, so this never wraps
    for (int i = 0; i < int'(N_PROD); i++) begin
      if (accept && bus.P == 2'(i + 1)) stock_d[i] = stock_q[i] - STOCK_W'(1);
    end

    if (state_d == RUN) begin
      case (code_d)
        2'd1:    motor_d = 3'b001;
        2'd2:    motor_d = 3'b010;
        2'd3:    motor_d = 3'b100;
        default: motor_d = 3'b000;
      endcase
    end

    busy_d = (state_d != IDLE);
    for (int i = 0; i < int'(N_PROD); i++) empty_d[i] = (stock_d[i] == '0);
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      code_q   <= 2'd0;
      motor_q  <= 3'b000;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      refund_q <= 1'b0;
      empty_q  <= 3'b000;
      last_p_q <= 2'd0;
      for (int i = 0; i < int'(N_PROD); i++) stock_q[i] <= STOCK_W'(STOCK_INIT);
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      code_q   <= code_d;
      motor_q  <= motor_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      refund_q <= refund_d;
      empty_q  <= empty_d;
      last_p_q <= last_p_d;
      for (int i = 0; i < int'(N_PROD); i++) stock_q[i] <= stock_d[i];
    end
  end

  assign bus.motor  = motor_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.refund = refund_q;
  assign bus.empty  = empty_q;
  assign bus.last_P = last_p_q;

endmodule

// File: tb/tb_vend_dispenser.sv
// Directed self-checking bench for vend_dispenser.
module tb_vend_dispenser;

  localparam int unsigned M = 8;
  localparam int unsigned S = 4;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  vend_dispenser_if bus ();

  vend_dispenser #(
    .MOTOR_CYCLES (M),
    .SETTLE_CYCLES(S),
    .STOCK_W      (3),
    .STOCK_INIT   (7)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One accepted dispense, followed through to its done pulse
  task automatic accept_run(input logic [1:0] p, input logic [2:0] exp_motor,
                            input logic [2:0] exp_empty);
    bus.A = 1'b1;
    bus.P = p;
    tick();
    bus.A = 1'b0;
    bus.P = 2'd0;
    chk("acc_busy", 8'(bus.busy), 8'd1);
    chk("acc_motor", 8'(bus.motor), 8'(exp_motor));
    chk("acc_empty", 8'(bus.empty), 8'(exp_empty));
    repeat (M + S - 1) tick();
    chk("pre_done", 8'(bus.done), 8'd0);
    tick();
    chk("done", 8'(bus.done), 8'd1);
    chk("done_busy", 8'(bus.busy), 8'd0);
    chk("last_P", 8'(bus.last_P), 8'(p));
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    reset      = 1'b1;
    bus.A      = 1'b0;
    bus.P      = 2'd0;
    bus.refill = 1'b0;

    // Reset state
    repeat (2) tick();
    chk("rst_motor", 8'(bus.motor), 8'd0);
    chk("rst_busy", 8'(bus.busy), 8'd0);
    chk("rst_done", 8'(bus.done), 8'd0);
    chk("rst_refund", 8'(bus.refund), 8'd0);
    chk("rst_empty", 8'(bus.empty), 8'd0);
    chk("rst_last_P", 8'(bus.last_P), 8'd0);
    reset = 1'b0;
    tick();

    // Test 1: single Pepsi dispense, cycle-by-cycle
    bus.A = 1'b1;
    bus.P = 2'd1;
    tick();
    bus.A = 1'b0;
    bus.P = 2'd0;
    for (int i = 0; i < int'(M); i++) begin
      chk("t1_run_motor", 8'(bus.motor), 8'h01);
      chk("t1_run_busy", 8'(bus.busy), 8'd1);
      chk("t1_run_done", 8'(bus.done), 8'd0);
      tick();
    end
    for (int i = 0; i < int'(S); i++) begin
      chk("t1_settle_motor", 8'(bus.motor), 8'h00);
      chk("t1_settle_busy", 8'(bus.busy), 8'd1);
      tick();
    end
    chk("t1_done", 8'(bus.done), 8'd1);
    chk("t1_busy_low", 8'(bus.busy), 8'd0);
    chk("t1_last_P", 8'(bus.last_P), 8'd1);
    chk("t1_empty", 8'(bus.empty), 8'd0);

    // Test 2: drain remaining six Pepsi back-to-back, then reject the next
    for (int k = 1; k <= 6; k++) begin
      accept_run(2'd1, 3'b001, (k == 6) ? 3'b001 : 3'b000);
    end
    bus.A = 1'b1;
    bus.P = 2'd1;
    tick();
    bus.A = 1'b0;
    bus.P = 2'd0;
    chk("t2_refund", 8'(bus.refund), 8'd1);
    chk("t2_motor", 8'(bus.motor), 8'd0);
    chk("t2_busy", 8'(bus.busy), 8'd0);
    chk("t2_empty", 8'(bus.empty), 8'h01);
    tick();
    chk("t2_refund_clr", 8'(bus.refund), 8'd0);

    // Test 3: P=00 rejected; two held cycles give two refund cycles
    bus.A = 1'b1;
    bus.P = 2'd0;
    tick();
    chk("t3_refund1", 8'(bus.refund), 8'd1);
    chk("t3_busy", 8'(bus.busy), 8'd0);
    tick();
    chk("t3_refund2", 8'(bus.refund), 8'd1);
    bus.A = 1'b0;
    tick();
    chk("t3_refund_clr", 8'(bus.refund), 8'd0);
    chk("t3_empty", 8'(bus.empty), 8'h01);

    // Refill in IDLE clears the Pepsi empty flag
    bus.refill = 1'b1;
    tick();
    bus.refill = 1'b0;
    chk("t5_refill_idle", 8'(bus.empty), 8'd0);

    // Test 4: request during RUN is refunded without disturbing the dispense
    bus.A = 1'b1;
    bus.P = 2'd1;
    tick();
    bus.A = 1'b0;
    bus.P = 2'd0;
    tick();
    tick();
    bus.A = 1'b1;
    bus.P = 2'd2;
    tick();
    bus.A = 1'b0;
    bus.P = 2'd0;
    chk("t4_refund", 8'(bus.refund), 8'd1);
    chk("t4_motor", 8'(bus.motor), 8'h01);
    chk("t4_busy", 8'(bus.busy), 8'd1);
    tick();
    chk("t4_refund_clr", 8'(bus.refund), 8'd0);
    repeat (7) tick();
    chk("t4_pre_done", 8'(bus.done), 8'd0);
    tick();
    chk("t4_done", 8'(bus.done), 8'd1);
    chk("t4_last_P", 8'(bus.last_P), 8'd1);

    // Coca must still hold 7: exactly seven accepts empty it
    for (int k = 1; k <= 7; k++) begin
      accept_run(2'd2, 3'b010, (k == 7) ? 3'b010 : 3'b000);
    end
    bus.A = 1'b1;
    bus.P = 2'd2;
    tick();
    bus.A = 1'b0;
    bus.P = 2'd0;
    chk("coca_refund", 8'(bus.refund), 8'd1);
    chk("coca_busy", 8'(bus.busy), 8'd0);

    // Test 5: refill during RUN is ignored
    bus.A = 1'b1;
    bus.P = 2'd3;
    tick();
    bus.A = 1'b0;
    bus.P = 2'd0;
    chk("t5_rb_motor", 8'(bus.motor), 8'h04);
    tick();
    bus.refill = 1'b1;
    tick();
    bus.refill = 1'b0;
    chk("t5_run_refill_empty", 8'(bus.empty), 8'h02);
    repeat (9) tick();
    chk("t5_pre_done", 8'(bus.done), 8'd0);
    tick();
    chk("t5_done", 8'(bus.done), 8'd1);
    chk("t5_after_empty", 8'(bus.empty), 8'h02);

    // Refill together with A: request wins, refill dropped
    bus.A      = 1'b1;
    bus.P      = 2'd3;
    bus.refill = 1'b1;
    tick();
    bus.A      = 1'b0;
    bus.P      = 2'd0;
    bus.refill = 1'b0;
    chk("t5_both_busy", 8'(bus.busy), 8'd1);
    chk("t5_both_motor", 8'(bus.motor), 8'h04);
    chk("t5_both_empty", 8'(bus.empty), 8'h02);
    repeat (M + S - 1) tick();
    tick();
    chk("t5_both_done", 8'(bus.done), 8'd1);
    chk("t5_both_last_P", 8'(bus.last_P), 8'd3);

    // Test 6: async reset mid-RUN of a Coca dispense
    bus.refill = 1'b1;
    tick();
    bus.refill = 1'b0;
    bus.A = 1'b1;
    bus.P = 2'd2;
    tick();
    bus.A = 1'b0;
    bus.P = 2'd0;
    chk("t6_motor_pre", 8'(bus.motor), 8'h02);
    tick();
    tick();
    reset = 1'b1;
    #2;
    chk("t6_motor_async", 8'(bus.motor), 8'd0);
    chk("t6_busy_async", 8'(bus.busy), 8'd0);
    chk("t6_last_P", 8'(bus.last_P), 8'd0);
    chk("t6_empty", 8'(bus.empty), 8'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < int'(M + S + 2); i++) begin
      tick();
      chk("t6_no_done", 8'(bus.done), 8'd0);
    end

    // Normal operation resumes after reset
    accept_run(2'd1, 3'b001, 3'b000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vend_dispenser.md
# vend_dispenser

Product-dispense actuator controller on the output side of the vending-machine credit FSM. It accepts the FSM's dispense strobe `A` and product code `P`, checks per-product stock, and drives one motor for a fixed time followed by a settle interval. It reports completion (`done`) or rejection (`refund`) and tracks inventory with per-product empty flags. The vending FSM and its credit logic sit upstream; motor drivers on the Basys 3 PMOD/LEDs sit downstream.

## Interface
Parameters:
- `MOTOR_CYCLES`, 8: cycles the motor output stays on per dispense. Must be ≥1.
- `SETTLE_CYCLES`, 4: motor-off cycles after motor-on before completion. Must be ≥1.
- `STOCK_W`, 3: width of each stock counter.
- `STOCK_INIT`, 7: stock per product after reset or refill. Must satisfy 1 ≤ `STOCK_INIT` ≤ 2^`STOCK_W`−1.

Ports:
- `clk` in 1: system clock. Single clock domain.
- `reset` in 1: asynchronous, active-high reset.
- `A` in 1: dispense request, sampled every rising edge.
- `P` in 2: product code. 00 = nada, 01 = Pepsi, 10 = Coca, 11 = RedBull.
- `refill` in 1: reload all stocks to `STOCK_INIT`.
- `motor` out 3: one-hot motor drive. bit0 = Pepsi, bit1 = Coca, bit2 = RedBull.
- `busy` out 1: high while a dispense is in progress.
- `done` out 1: one-cycle pulse when a dispense completes.
- `refund` out 1: one-cycle pulse when a request is rejected.
- `empty` out 3: per-product stock==0 flags, same bit order as `motor`.
- `last_P` out 2: code of the last completed dispense.

## Operation
- State machine states: IDLE, RUN, SETTLE. The down-counter `timer` is sized to max(`MOTOR_CYCLES`, `SETTLE_CYCLES`).
- IDLE:
  - A request is valid when `A`=1, `P`≠00, and stock[`P`]≠0.
  - On a valid request: latch `P` into `code`, decrement stock[`P`], load `timer`=`MOTOR_CYCLES`−1, go to RUN.
  - `A`=1 with `P`=00 or stock[`P`]=0: `refund`=1 next cycle, stay in IDLE, no stock change.
  - `refill`=1 with `A`=0: all three stocks are set to `STOCK_INIT`.
  - `refill`=1 with `A`=1 in the same cycle: the request is processed and `refill` is ignored.
- RUN:
  - `motor`[`code`−1]=1 and `busy`=1. `timer` decrements each cycle.
  - At `timer`=0, load `timer`=`SETTLE_CYCLES`−1 and go to SETTLE.
- SETTLE:
  - `motor`=000 and `busy`=1. `timer` decrements each cycle.
  - At `timer`=0, go to IDLE, `done`=1 for one cycle, `last_P`←`code`.
- `A`=1 while in RUN or SETTLE: `refund`=1 next cycle. The request is dropped and the active dispense and all stocks are unaffected.
- `refill` while in RUN or SETTLE is ignored.
- Stock counters never wrap. Decrement occurs only on accept, and accept requires stock≠0.
- `empty`[i] = (stock[i]==0), decoded from the stock registers.
- All outputs are registered or decoded directly from state registers. There is no combinational path from inputs to outputs.

## Timing
- Reset values (applied asynchronously when `reset`=1):
  - state = IDLE, `motor`=000, `busy`=0, `done`=0, `refund`=0, `last_P`=00.
  - all stocks = `STOCK_INIT`, so `empty`=000.
- Accepting edge E0:
  - `busy`=1 and `motor` active from E0 for exactly `MOTOR_CYCLES` cycles, then `motor`=000 for `SETTLE_CYCLES` cycles.
  - `empty` reflects the decremented stock from E0.
- Completion: `done`=1 and `busy`=0 in the cycle after edge E0+`MOTOR_CYCLES`+`SETTLE_CYCLES` (12 with defaults). `last_P` updates on that same edge.
- Back-to-back: a request presented while `done`=1 is accepted (IDLE). Minimum accept spacing is `MOTOR_CYCLES`+`SETTLE_CYCLES` edges.
- `refund` is high for exactly one cycle after the rejecting edge. Consecutive rejected cycles produce consecutive `refund` cycles.
- `done` and `refund` can both be high in the same cycle only if the completing edge also sampled a rejectable request. Since the block is not in IDLE at that edge, `A` at that edge is rejected.
- Reset asserted mid-RUN or mid-SETTLE: `motor` drops immediately, no `done` pulse, stocks return to `STOCK_INIT`.

## Test plan
1. Reset, then `A`=1, `P`=01 for one cycle.
   - `motor`=001 for 8 cycles, then 000.
   - `busy`=1 for 12 cycles.
   - `done` pulses at edge +12, `last_P`=01, Pepsi stock=6, `empty`=000.
2. Seven Pepsi dispenses complete, then an eighth `A`=1, `P`=01.
   - `empty`=001 after the seventh accept.
   - The eighth request gives `refund` for one cycle, `motor` stays 000, `busy` stays 0.
3. `A`=1, `P`=00 in IDLE.
   - `refund` for one cycle, `busy`=0, stocks unchanged.
4. Pepsi dispense started; at RUN cycle 3, `A`=1, `P`=10.
   - `refund` for one cycle, `motor` stays 001, Coca stock stays 7, `done` still at edge +12.
5. Refill handling, starting with Pepsi empty:
   - `refill` in IDLE: `empty`=000 next cycle.
   - `refill` during RUN: ignored.
   - `refill`+`A`(`P`=11) in the same cycle: RedBull dispenses, other stocks unchanged.
6. `reset` pulsed during RUN cycle 3 of a Coca dispense.
   - `motor`=000 immediately, no `done`, all stocks=7, `last_P`=00.
